// File: rtl/dual_issue_scoreboard.sv
// In-order dual-issue controller: tracks pending register writes and an
// in-flight mult/div op, and decides each cycle whether slots A and B issue.
module dual_issue_scoreboard #(
    parameter int CNT_W = 32
) (
    input  logic             clock,
    input  logic             ctrl_reset,
    input  logic             A_valid,
    input  logic [4:0]       A_rs1,
    input  logic [4:0]       A_rs2,
    input  logic [4:0]       A_rd,
    input  logic             A_wen,
    input  logic             A_long,
    input  logic             B_valid,
    input  logic [4:0]       B_rs1,
    input  logic [4:0]       B_rs2,
    input  logic [4:0]       B_rd,
    input  logic             B_wen,
    input  logic             B_long,
    input  logic             wbA_en,
    input  logic [4:0]       wbA_reg,
    input  logic             wbB_en,
    input  logic [4:0]       wbB_reg,
    input  logic             long_done,
    output logic             A_issue,
    output logic             B_issue,
    output logic [31:0]      busy,
    output logic             long_busy,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] dual_count
);

    logic [31:0]      r_busy;
    logic             r_longBusy;
    logic [CNT_W-1:0] r_stallCount;
    logic [CNT_W-1:0] r_dualCount;

    logic             w_aHazard;
    logic             w_bHazard;
    logic             w_pairHazard;
    logic             w_aIssue;
    logic             w_bIssue;
    logic [31:0]      w_busyNext;
    logic             w_longSet;

    // Hazards against registered state only; a writeback unblocks next cycle.
    always_comb begin
        w_aHazard = ((A_rs1 != 5'd0) && r_busy[A_rs1])
                  || ((A_rs2 != 5'd0) && r_busy[A_rs2])
                  || (A_wen && (A_rd != 5'd0) && r_busy[A_rd])
                  || (A_long && r_longBusy);
        w_bHazard = ((B_rs1 != 5'd0) && r_busy[B_rs1])
                  || ((B_rs2 != 5'd0) && r_busy[B_rs2])
                  || (B_wen && (B_rd != 5'd0) && r_busy[B_rd])
                  || (B_long && r_longBusy);
        w_pairHazard = (A_long && B_long);
        if (A_wen && (A_rd != 5'd0)) begin
            if ((B_rs1 == A_rd) || (B_rs2 == A_rd) || (B_wen && (B_rd == A_rd))) begin
                w_pairHazard = 1'b1;
            end
        end
    end

    assign w_aIssue = !ctrl_reset && A_valid && !w_aHazard;
    assign w_bIssue = w_aIssue && B_valid && !w_bHazard && !w_pairHazard;

    // Clears are applied first so a same-cycle set on the same register wins.
    always_comb begin
        w_busyNext = r_busy;
        if (wbA_en) begin
            w_busyNext[wbA_reg] = 1'b0;
        end
        if (wbB_en) begin
            w_busyNext[wbB_reg] = 1'b0;
        end
        if (w_aIssue && A_wen) begin
            w_busyNext[A_rd] = 1'b1;
        end
        if (w_bIssue && B_wen) begin
            w_busyNext[B_rd] = 1'b1;
        end
        w_busyNext[0] = 1'b0;
    end

    assign w_longSet = (w_aIssue && A_long) || (w_bIssue && B_long);

    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            r_busy     <= 32'd0;
            r_longBusy <= 1'b0;
        end else begin
            r_busy <= w_busyNext;
            if (w_longSet) begin
                r_longBusy <= 1'b1;
            end else if (long_done) begin
                r_longBusy <= 1'b0;
            end
        end
    end

    // Performance counters stick at all-ones rather than wrapping.
    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            r_stallCount <= '0;
            r_dualCount  <= '0;
        end else begin
            if (A_valid && !w_aIssue && (r_stallCount != {CNT_W{1'b1}})) begin
                r_stallCount <= r_stallCount + CNT_W'(1);
            end
            if (w_aIssue && w_bIssue && (r_dualCount != {CNT_W{1'b1}})) begin
                r_dualCount <= r_dualCount + CNT_W'(1);
            end
        end
    end

    assign A_issue     = w_aIssue;
    assign B_issue     = w_bIssue;
    assign busy        = r_busy;
    assign long_busy   = r_longBusy;
    assign stall_count = r_stallCount;
    assign dual_count  = r_dualCount;

endmodule

// File: tb/tb_dual_issue_scoreboard.sv
// Bench for dual_issue_scoreboard: directed scenarios then randomized traffic,
// with expected responses queued by the driver and compared by a monitor.
module tb_dual_issue_scoreboard;

    localparam int CNT_W = 6;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct packed {
        logic       aValid;
        logic [4:0] aRs1;
        logic [4:0] aRs2;
        logic [4:0] aRd;
        logic       aWen;
        logic       aLong;
        logic       bValid;
        logic [4:0] bRs1;
        logic [4:0] bRs2;
        logic [4:0] bRd;
        logic       bWen;
        logic       bLong;
        logic       wbAEn;
        logic [4:0] wbAReg;
        logic       wbBEn;
        logic [4:0] wbBReg;
        logic       longDone;
    } stim_t;

    typedef struct {
        logic        expA;
        logic        expB;
        logic [31:0] expBusy;
        logic        expLong;
        int          expStall;
        int          expDual;
    } exp_t;

    logic             clock;
    logic             ctrl_reset;
    logic             A_valid, A_wen, A_long;
    logic [4:0]       A_rs1, A_rs2, A_rd;
    logic             B_valid, B_wen, B_long;
    logic [4:0]       B_rs1, B_rs2, B_rd;
    logic             wbA_en, wbB_en, long_done;
    logic [4:0]       wbA_reg, wbB_reg;
    logic             A_issue, B_issue, long_busy;
    logic [31:0]      busy;
    logic [CNT_W-1:0] stall_count, dual_count;

    int checkCount = 0;
    int errorCount = 0;

    exp_t  expQ[$];
    bit    mBusy[32];
    bit    mLong;
    int    mStall;
    int    mDual;
    stim_t lastStim;
    bit    lastA, lastB, hasLast;

    dual_issue_scoreboard #(.CNT_W(CNT_W)) dut (
        .clock(clock), .ctrl_reset(ctrl_reset),
        .A_valid(A_valid), .A_rs1(A_rs1), .A_rs2(A_rs2), .A_rd(A_rd),
        .A_wen(A_wen), .A_long(A_long),
        .B_valid(B_valid), .B_rs1(B_rs1), .B_rs2(B_rs2), .B_rd(B_rd),
        .B_wen(B_wen), .B_long(B_long),
        .wbA_en(wbA_en), .wbA_reg(wbA_reg), .wbB_en(wbB_en), .wbB_reg(wbB_reg),
        .long_done(long_done),
        .A_issue(A_issue), .B_issue(B_issue), .busy(busy), .long_busy(long_busy),
        .stall_count(stall_count), .dual_count(dual_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic bit blocked(input logic [4:0] r);
        return (r != 5'd0) && mBusy[r];
    endfunction

    function automatic logic [31:0] busyVec();
        logic [31:0] v = '0;
        for (int i = 1; i < 32; i++) v[i] = mBusy[i];
        return v;
    endfunction

    // Issue rules written directly from the slot-eligibility definitions.
    function automatic void modelIssue(input stim_t s, output bit a, output bit b);
        bit pairOk;
        a = s.aValid && !blocked(s.aRs1) && !blocked(s.aRs2)
            && !(s.aWen && blocked(s.aRd)) && !(s.aLong && mLong);
        pairOk = !(s.aLong && s.bLong);
        if (s.aWen && s.aRd != 0 &&
            (s.bRs1 == s.aRd || s.bRs2 == s.aRd || (s.bWen && s.bRd == s.aRd)))
            pairOk = 0;
        b = a && s.bValid && pairOk && !blocked(s.bRs1) && !blocked(s.bRs2)
            && !(s.bWen && blocked(s.bRd)) && !(s.bLong && mLong);
    endfunction

    function automatic void modelCommit();
        if (!hasLast) return;
        if (lastStim.wbAEn) mBusy[lastStim.wbAReg] = 0;
        if (lastStim.wbBEn) mBusy[lastStim.wbBReg] = 0;
        if (lastA && lastStim.aWen) mBusy[lastStim.aRd] = 1;
        if (lastB && lastStim.bWen) mBusy[lastStim.bRd] = 1;
        mBusy[0] = 0;
        if ((lastA && lastStim.aLong) || (lastB && lastStim.bLong)) mLong = 1;
        else if (lastStim.longDone) mLong = 0;
        if (lastStim.aValid && !lastA && mStall < CNT_MAX) mStall++;
        if (lastA && lastB && mDual < CNT_MAX) mDual++;
    endfunction

    function automatic void modelReset();
        foreach (mBusy[i]) mBusy[i] = 0;
        mLong = 0; mStall = 0; mDual = 0; hasLast = 0;
    endfunction

    task automatic driveInputs(input stim_t s);
        A_valid = s.aValid; A_rs1 = s.aRs1; A_rs2 = s.aRs2; A_rd = s.aRd;
        A_wen = s.aWen; A_long = s.aLong;
        B_valid = s.bValid; B_rs1 = s.bRs1; B_rs2 = s.bRs2; B_rd = s.bRd;
        B_wen = s.bWen; B_long = s.bLong;
        wbA_en = s.wbAEn; wbA_reg = s.wbAReg; wbB_en = s.wbBEn; wbB_reg = s.wbBReg;
        long_done = s.longDone;
    endtask

    // One cycle: retire the previous cycle into the model, drive, queue expectation.
    task automatic applyStimulus(input stim_t s);
        exp_t e;
        bit a, b;
        @(posedge clock);
        modelCommit();
        #1;
        driveInputs(s);
        modelIssue(s, a, b);
        e.expA = a; e.expB = b; e.expBusy = busyVec(); e.expLong = mLong;
        e.expStall = mStall; e.expDual = mDual;
        expQ.push_back(e);
        lastStim = s; lastA = a; lastB = b; hasLast = 1;
    endtask

    function automatic stim_t mkPair(
        input logic av, input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] ad,
        input logic aw, input logic al,
        input logic bv, input logic [4:0] b1, input logic [4:0] b2, input logic [4:0] bd,
        input logic bw, input logic bl);
        stim_t s = '0;
        s.aValid = av; s.aRs1 = a1; s.aRs2 = a2; s.aRd = ad; s.aWen = aw; s.aLong = al;
        s.bValid = bv; s.bRs1 = b1; s.bRs2 = b2; s.bRd = bd; s.bWen = bw; s.bLong = bl;
        return s;
    endfunction

    // Reset asserted between clock edges; outputs must clear without a clock.
    task automatic doReset();
        #1;
        ctrl_reset = 1'b1;
        expQ.delete();
        driveInputs(mkPair(1, 0, 0, 5'd3, 1, 0, 1, 0, 0, 5'd4, 1, 0));
        #1;
        checkOutput("reset_busy", busy, 32'd0);
        checkOutput("reset_long_busy", {31'd0, long_busy}, 32'd0);
        checkOutput("reset_stall_count", {26'd0, stall_count}, 32'd0);
        checkOutput("reset_dual_count", {26'd0, dual_count}, 32'd0);
        checkOutput("reset_A_issue", {31'd0, A_issue}, 32'd0);
        checkOutput("reset_B_issue", {31'd0, B_issue}, 32'd0);
        modelReset();
        @(posedge clock);
        #1;
        driveInputs('0);
        ctrl_reset = 1'b0;
    endtask

    function automatic logic [4:0] pickReg();
        if ($urandom_range(0, 99) < 70) return 5'($urandom_range(0, 7));
        return 5'($urandom_range(0, 31));
    endfunction

    function automatic logic [4:0] pickWbReg();
        int cands[$];
        for (int i = 1; i < 32; i++) if (mBusy[i]) cands.push_back(i);
        if (cands.size() > 0 && $urandom_range(0, 99) < 80)
            return 5'(cands[$urandom_range(0, cands.size() - 1)]);
        return 5'($urandom_range(0, 31));
    endfunction

    function automatic stim_t randomStim();
        stim_t s = '0;
        s.aValid = ($urandom_range(0, 99) < 85);
        s.aRs1 = pickReg(); s.aRs2 = pickReg(); s.aRd = pickReg();
        s.aWen = ($urandom_range(0, 99) < 70); s.aLong = ($urandom_range(0, 99) < 10);
        s.bValid = ($urandom_range(0, 99) < 85);
        s.bRs1 = pickReg(); s.bRs2 = pickReg(); s.bRd = pickReg();
        s.bWen = ($urandom_range(0, 99) < 70); s.bLong = ($urandom_range(0, 99) < 10);
        s.wbAEn = ($urandom_range(0, 99) < 45); s.wbAReg = pickWbReg();
        s.wbBEn = ($urandom_range(0, 99) < 45); s.wbBReg = pickWbReg();
        s.longDone = ($urandom_range(0, 99) < 15);
        return s;
    endfunction

    // Monitor: compares every queued expectation on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (!ctrl_reset && expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("sb_A_issue", {31'd0, A_issue}, {31'd0, e.expA});
                checkOutput("sb_B_issue", {31'd0, B_issue}, {31'd0, e.expB});
                checkOutput("sb_busy", busy, e.expBusy);
                checkOutput("sb_long_busy", {31'd0, long_busy}, {31'd0, e.expLong});
                checkOutput("sb_stall_count", {26'd0, stall_count}, e.expStall);
                checkOutput("sb_dual_count", {26'd0, dual_count}, e.expDual);
            end
        end
    end

    initial begin
        stim_t s;
        ctrl_reset = 1'b1;
        driveInputs('0);
        modelReset();
        repeat (2) @(posedge clock);
        #1 ctrl_reset = 1'b0;

        // Fill x4..x7, then reset mid-cycle.
        applyStimulus(mkPair(1, 0, 0, 5'd4, 1, 0, 1, 0, 0, 5'd5, 1, 0));
        applyStimulus(mkPair(1, 0, 0, 5'd6, 1, 0, 1, 0, 0, 5'd7, 1, 0));
        applyStimulus('0);
        #1 checkOutput("prefill_busy", busy, 32'h0000_00F0);
        doReset();

        // Independent pair.
        applyStimulus(mkPair(1, 5'd1, 5'd2, 5'd5, 1, 0, 1, 5'd3, 5'd4, 5'd6, 1, 0));
        #1 checkOutput("indep_A_issue", {31'd0, A_issue}, 32'd1);
        checkOutput("indep_B_issue", {31'd0, B_issue}, 32'd1);
        // Intra-pair RAW on x7.
        applyStimulus(mkPair(1, 0, 0, 5'd7, 1, 0, 1, 5'd7, 0, 5'd8, 1, 0));
        #1 checkOutput("indep_busy_next", busy, 32'h0000_0060);
        checkOutput("indep_dual_count", {26'd0, dual_count}, 32'd1);
        checkOutput("raw_A_issue", {31'd0, A_issue}, 32'd1);
        checkOutput("raw_B_issue", {31'd0, B_issue}, 32'd0);

        // Busy stall on x5, writeback, then issue one cycle later.
        s = mkPair(1, 5'd5, 0, 5'd12, 1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(s);
        #1 checkOutput("raw_busy_next", busy, 32'h0000_00E0);
        checkOutput("stall_A_issue", {31'd0, A_issue}, 32'd0);
        s.wbAEn = 1; s.wbAReg = 5'd5;
        applyStimulus(s);
        #1 checkOutput("wb_cycle_A_issue", {31'd0, A_issue}, 32'd0);
        checkOutput("stall_count_1", {26'd0, stall_count}, 32'd1);
        s.wbAEn = 0;
        applyStimulus(s);
        #1 checkOutput("after_wb_A_issue", {31'd0, A_issue}, 32'd1);
        checkOutput("stall_count_2", {26'd0, stall_count}, 32'd2);
        checkOutput("after_wb_busy", busy, 32'h0000_00C0);

        // Write to x9 coinciding with a port-B writeback of x9.
        s = mkPair(1, 0, 0, 5'd9, 1, 0, 0, 0, 0, 0, 0, 0);
        s.wbBEn = 1; s.wbBReg = 5'd9;
        applyStimulus(s);

        // Long op, second long op stalls until long_done, then issues.
        applyStimulus(mkPair(1, 0, 0, 5'd10, 1, 1, 0, 0, 0, 0, 0, 0));
        #1 checkOutput("set_wins_busy9", {31'd0, busy[9]}, 32'd1);
        s = mkPair(1, 0, 0, 5'd11, 1, 1, 0, 0, 0, 0, 0, 0);
        applyStimulus(s);
        #1 checkOutput("long_busy_set", {31'd0, long_busy}, 32'd1);
        checkOutput("long_stall_A_issue", {31'd0, A_issue}, 32'd0);
        s.longDone = 1; s.wbAEn = 1; s.wbAReg = 5'd10;
        applyStimulus(s);
        #1 checkOutput("long_done_cycle_A_issue", {31'd0, A_issue}, 32'd0);
        s.longDone = 0; s.wbAEn = 0;
        applyStimulus(s);
        #1 checkOutput("long_after_done_A_issue", {31'd0, A_issue}, 32'd1);
        checkOutput("long_busy_cleared", {31'd0, long_busy}, 32'd0);

        // Writes to x0 never mark it busy.
        applyStimulus(mkPair(1, 0, 0, 5'd0, 1, 0, 1, 5'd0, 0, 5'd0, 1, 0));
        #1 checkOutput("x0_pair_B_issue", {31'd0, B_issue}, 32'd1);
        applyStimulus('0);
        #1 checkOutput("x0_never_busy", {31'd0, busy[0]}, 32'd0);
        checkOutput("long_busy_second", {31'd0, long_busy}, 32'd1);

        // Randomized traffic with one reset in the middle.
        for (int i = 0; i < 1500; i++) begin
            applyStimulus(randomStim());
            if (i == 700) doReset();
        end
        applyStimulus('0);
        repeat (2) @(negedge clock);
        checkOutput("queue_drained", expQ.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/dual_issue_scoreboard.md
Name: dual_issue_scoreboard

Overview:
- In-order issue controller for the dual-issue pipeline.
- Tracks which architectural registers have an in-flight write pending on the two-write-port register file.
- Decides each cycle whether issue slot A, and optionally slot B, may proceed.
- Sits between decode and the register-file read stage; writeback ports A/B and the long-latency (mult/div) unit report completions back to it.

Parameters:
CNT_W, 32, width of the performance counters stall_count and dual_count.

Ports:
clock  in  1  system clock; all state updates on posedge
ctrl_reset  in  1  asynchronous, active-high reset
A_valid  in  1  slot A holds a decoded instruction
A_rs1  in  5  slot A source register 1 (decoder drives 0 if unused)
A_rs2  in  5  slot A source register 2 (decoder drives 0 if unused)
A_rd  in  5  slot A destination register
A_wen  in  1  slot A writes A_rd
A_long  in  1  slot A is a mult/div op
B_valid, B_rs1, B_rs2, B_rd, B_wen, B_long  in  1/5/5/5/1/1  same meaning for slot B (younger instruction)
wbA_en  in  1  write port A commits this cycle
wbA_reg  in  5  register written by port A
wbB_en  in  1  write port B commits this cycle
wbB_reg  in  5  register written by port B
long_done  in  1  mult/div result is on a writeback port this cycle
A_issue  out  1  slot A issues this cycle (combinational)
B_issue  out  1  slot B issues this cycle (combinational)
busy  out  32  per-register pending-write bits; bit 0 always 0
long_busy  out  1  a mult/div op is in flight
stall_count  out  CNT_W  cycles with A_valid=1 and A_issue=0
dual_count  out  CNT_W  cycles with both slots issued

Behaviour:
Reset:
- ctrl_reset asynchronously clears busy, long_busy, stall_count and dual_count to 0.
- While in reset, A_issue=B_issue=0.

Definitions:
- Register r is "blocked" when r!=0 and busy[r]=1. Register 0 is never blocked.
- Busy state is the registered value only. No same-cycle writeback bypass is provided: the register file writes on the clock edge, so a register cleared by writeback becomes issuable the next cycle.

A_issue = A_valid, and all of:
- rs1 not blocked
- rs2 not blocked
- not (A_wen and rd blocked) — WAW check
- not (A_long and long_busy)

B_issue = A_issue, B_valid, and the same four checks for slot B, and additionally:
- if A_wen and A_rd!=0: B_rs1!=A_rd, B_rs2!=A_rd, and not (B_wen and B_rd==A_rd) — intra-pair RAW/WAW
- not (A_long and B_long)
- Slot B never issues without slot A (strict in-order issue).

Next-state for busy[r], r!=0:
- Set if an issuing slot has wen=1 and rd=r.
- Else cleared if wbA_en and wbA_reg=r, or wbB_en and wbB_reg=r.
- Else held.
- Set wins over clear in the same cycle.
- Both write ports clearing the same r in one cycle is legal.
- Writeback to a register that is not busy has no effect.

long_busy:
- Set when an issuing slot has long=1.
- Cleared when long_done=1.
- A set cannot coincide with long_done, because a long op cannot issue while long_busy=1.
- long_done with long_busy=0 is ignored.

Counters:
- stall_count increments when A_valid and !A_issue.
- dual_count increments when A_issue and B_issue.
- Both saturate at all-ones and never wrap.

Latency:
- Issue decision: 0 cycles (combinational from inputs and registered state).
- Issue-to-busy visible: 1 cycle.
- Writeback-to-unblock: 1 cycle.

Reset mid-operation:
- All pending bits are dropped.
- Later writebacks to those registers are harmless no-ops.

Test Plan:
1. Reset: assert ctrl_reset asynchronously mid-cycle with busy=0x0000_00F0 -> busy, long_busy and both counters read 0 immediately; A_issue=B_issue=0.
2. Independent pair: A = add x5,x1,x2; B = add x6,x3,x4 -> A_issue=B_issue=1; next cycle busy=0x0000_0060, dual_count=1.
3. Intra-pair RAW: A writes x7; B reads x7 -> A_issue=1, B_issue=0; next cycle busy[7]=1.
4. Busy stall and wb: busy[5]=1; A reads x5 -> A_issue=0 and stall_count increments; pulse wbA_en with wbA_reg=5 -> A still stalls that cycle, A_issue=1 the following cycle.
5. Simultaneous set/clear: wbB clears x9 in the same cycle slot A issues a write to x9 -> busy[9]=1 afterwards.
6. Long op and x0: issue A_long with rd=x10 -> long_busy=1; a second long op stalls until the long_done+wb cycle, then issues next cycle; separately, rd=x0 with wen=1 never sets busy[0].
